// File: rtl/iq_to_float.sv
// Three-stage streaming converter: signed fixed-point IQ sample -> IEEE-754 single float.
// Optional per-beat power-of-two scaling with saturation to inf / flush to zero: IQ_TO_FLOAT_SCALE_EN.
module iq_to_float #(
   parameter int BITS_IN = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [BITS_IN-1:0] i_tdata,
   input  logic               i_tlast,
   input  logic               i_tvalid,
   output logic               i_tready,
   output logic [31:0]        o_tdata,
   output logic               o_tlast,
   output logic               o_tvalid,
   input  logic               o_tready
`ifdef IQ_TO_FLOAT_SCALE_EN
   ,
   input  logic [7:0]         scale_exp
`endif
);

   localparam int PAD = 24 - BITS_IN;

   logic s1_v, s2_v, s3_v;
   logic en1, en2, en3;

   logic               s1_sign, s1_last;
   logic [BITS_IN-1:0] s1_mag;
   logic               s2_sign, s2_last, s2_zero;
   logic [23:0]        s2_mag24;
   logic [4:0]         s2_p;
   logic [31:0]        s3_data;
   logic               s3_last;

   // A stage may load when it is empty or its contents leave this cycle.
   assign en3      = !s3_v || o_tready;
   assign en2      = !s2_v || en3;
   assign en1      = !s1_v || en2;
   assign i_tready = en1;
   assign o_tvalid = s3_v;
   assign o_tdata  = s3_data;
   assign o_tlast  = s3_last;

   function automatic logic [4:0] lead_one(input logic [23:0] v);
      lead_one = 5'd0;
      for (int k = 0; k < 24; k++) begin
         if (v[k]) lead_one = 5'(k);
      end
   endfunction

   logic [23:0] mag24_in;
   assign mag24_in = 24'(s1_mag) << PAD;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
      end else begin
         if (en1) s1_v <= i_tvalid;
         if (en2) s2_v <= s1_v;
         if (en3) s3_v <= s2_v;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_sign <= 1'b0;
         s1_mag  <= '0;
         s1_last <= 1'b0;
      end else if (en1 && i_tvalid) begin
         s1_sign <= i_tdata[BITS_IN-1];
         s1_mag  <= i_tdata[BITS_IN-1] ? -i_tdata : i_tdata;
         s1_last <= i_tlast;
      end
   end

   // Magnitude is re-based to 24 bits so the exponent bias no longer depends on BITS_IN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_sign  <= 1'b0;
         s2_mag24 <= '0;
         s2_p     <= '0;
         s2_zero  <= 1'b1;
         s2_last  <= 1'b0;
      end else if (en2 && s1_v) begin
         s2_sign  <= s1_sign;
         s2_mag24 <= mag24_in;
         s2_p     <= lead_one(mag24_in);
         s2_zero  <= (mag24_in == 24'd0);
         s2_last  <= s1_last;
      end
   end

   logic [23:0] norm;
   logic [31:0] packed_word;
   assign norm = s2_mag24 << (5'd23 - s2_p);

`ifdef IQ_TO_FLOAT_SCALE_EN
   logic [7:0] s1_scale, s2_scale;
   logic signed [9:0] exp_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_scale <= '0;
         s2_scale <= '0;
      end else begin
         if (en1 && i_tvalid) s1_scale <= scale_exp;
         if (en2 && s1_v)     s2_scale <= s1_scale;
      end
   end

   // Value = mag24 / 2^23, so the biased exponent is 127 + p - 23.
   assign exp_full = 10'sd104 + signed'({5'd0, s2_p}) + signed'({{2{s2_scale[7]}}, s2_scale});

   always_comb begin
      packed_word = {s2_sign, exp_full[7:0], norm[22:0]};
      if (s2_zero)
         packed_word = 32'd0;
      else if (exp_full > 10'sd254)
         packed_word = {s2_sign, 8'hFF, 23'd0};
      else if (exp_full < 10'sd1)
         packed_word = {s2_sign, 31'd0};
   end
`else
   logic [7:0] exp_biased;
   assign exp_biased = 8'd104 + {3'd0, s2_p};

   always_comb begin
      packed_word = {s2_sign, exp_biased, norm[22:0]};
      if (s2_zero) packed_word = 32'd0;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s3_data <= 32'd0;
         s3_last <= 1'b0;
      end else if (en3 && s2_v) begin
         s3_data <= packed_word;
         s3_last <= s2_last;
      end
   end

endmodule
